// File: rtl/csr_trace_serializer.sv
// csr_trace_serializer
// Commit-stage companion of the CSR unit. On a snapshot request it copies the
// whole CSR bundle into shadow registers and streams it out as a framed
// sequence of 64-bit words on a valid/ready trace port. It only observes CSRs.
//
// csr_pack[k] is the k-th 64-bit field of the CSR bundle in declaration order:
// csr_pack[0] is sstatus and csr_pack[26] is csr_ret. Frame layout is an
// optional header word {FRAME_TAG, 16'h0000, seq} followed by the 27 fields
// in that same order.

module csr_trace_serializer #(
    parameter int unsigned HEADER_EN = 1,
    parameter logic [15:0] FRAME_TAG = 16'hC5A0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              snap_valid,
    input  logic [26:0][63:0] csr_pack,
    output logic              snap_busy,
    output logic              out_valid,
    output logic [63:0]       out_data,
    output logic [4:0]        out_idx,
    output logic              out_last,
    input  logic              out_ready,
    output logic [31:0]       frame_cnt,
    output logic [15:0]       drop_cnt
);

    localparam int unsigned NUM_FIELDS = 27;
    localparam int unsigned HDR        = (HEADER_EN != 0) ? 1 : 0;
    localparam int unsigned NUM_WORDS  = NUM_FIELDS + HDR;
    localparam logic [4:0]  LAST_IDX   = 5'(NUM_WORDS - 1);
    localparam logic [4:0]  HDR_OFS    = 5'(HDR);
    localparam logic [4:0]  FIELD_LIM  = 5'(NUM_FIELDS);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // Sequential state
    state_t      state_q;
    logic [63:0] shadow_q [NUM_FIELDS];
    logic [31:0] seq_q;
    logic        out_valid_q;
    logic [63:0] out_data_q;
    logic [4:0]  out_idx_q;
    logic        out_last_q;
    logic        snap_busy_q;
    logic [31:0] frame_cnt_q;
    logic [15:0] drop_cnt_q;

    // Next-state helpers
    logic        handshake_d;
    logic        final_hs_d;
    logic        capture_d;
    logic        drop_d;
    logic [4:0]  next_idx_d;
    logic [4:0]  field_sel_d;
    logic [63:0] next_word_d;
    logic [63:0] first_word_d;

    // Handshake, capture/drop decisions and the next word to present.
    // A request is only taken when idle or on the final-word handshake, so
    // back-to-back frames run without a bubble.
    always_comb begin
        handshake_d  = out_valid_q && out_ready;
        final_hs_d   = handshake_d && out_last_q;
        capture_d    = snap_valid && ((state_q == ST_IDLE) || final_hs_d);
        drop_d       = snap_valid && (state_q == ST_SEND) && !final_hs_d;
        next_idx_d   = out_idx_q + 5'd1;
        field_sel_d  = next_idx_d - HDR_OFS;
        next_word_d  = 64'd0;
        if (field_sel_d < FIELD_LIM) begin
            next_word_d = shadow_q[field_sel_d];
        end
        // Word 0 is built from live inputs because the shadow copy is only
        // being written on this same edge.
        first_word_d = (HDR != 0) ? {FRAME_TAG, 16'h0000, seq_q} : csr_pack[0];
    end

    // Shadow copy of the CSR bundle, refreshed only when a capture is accepted
    // so later csr_pack changes cannot leak into a frame in flight.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_FIELDS; i++) begin
                shadow_q[i] <= 64'd0;
            end
        end else if (capture_d) begin
            for (int i = 0; i < NUM_FIELDS; i++) begin
                shadow_q[i] <= csr_pack[i];
            end
        end
    end

    // Frame FSM with registered port outputs, sequence and statistics counters.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            seq_q       <= 32'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 64'd0;
            out_idx_q   <= 5'd0;
            out_last_q  <= 1'b0;
            snap_busy_q <= 1'b0;
            frame_cnt_q <= 32'd0;
            drop_cnt_q  <= 16'd0;
        end else begin
            if (capture_d) begin
                seq_q <= seq_q + 32'd1;
            end
            if (final_hs_d) begin
                frame_cnt_q <= frame_cnt_q + 32'd1;
            end
            if (drop_d && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (capture_d) begin
                        state_q     <= ST_SEND;
                        out_valid_q <= 1'b1;
                        snap_busy_q <= 1'b1;
                        out_idx_q   <= 5'd0;
                        out_last_q  <= 1'b0;
                        out_data_q  <= first_word_d;
                    end
                end
                ST_SEND: begin
                    if (handshake_d) begin
                        if (out_last_q) begin
                            if (capture_d) begin
                                // Chained frame: word 0 follows immediately.
                                out_valid_q <= 1'b1;
                                snap_busy_q <= 1'b1;
                                out_idx_q   <= 5'd0;
                                out_last_q  <= 1'b0;
                                out_data_q  <= first_word_d;
                            end else begin
                                state_q     <= ST_IDLE;
                                out_valid_q <= 1'b0;
                                snap_busy_q <= 1'b0;
                                out_idx_q   <= 5'd0;
                                out_last_q  <= 1'b0;
                            end
                        end else begin
                            out_idx_q  <= next_idx_d;
                            out_data_q <= next_word_d;
                            out_last_q <= (next_idx_d == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                    snap_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign snap_busy = snap_busy_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign frame_cnt = frame_cnt_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_csr_trace_serializer.sv
// Scoreboard bench for csr_trace_serializer: stimulus pushes the expected
// beats of each frame, monitors pop and compare on every handshake.

module tb_csr_trace_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rstn;
    logic              snap_valid;
    logic              snap_valid0;
    logic              out_ready;
    logic [26:0][63:0] csr_pack;

    logic        snap_busy,  out_valid,  out_last;
    logic [63:0] out_data;
    logic [4:0]  out_idx;
    logic [31:0] frame_cnt;
    logic [15:0] drop_cnt;

    logic        snap_busy0, out_valid0, out_last0;
    logic [63:0] out_data0;
    logic [4:0]  out_idx0;
    logic [31:0] frame_cnt0;
    logic [15:0] drop_cnt0;

    csr_trace_serializer #(.HEADER_EN(1), .FRAME_TAG(16'hC5A0)) dut (
        .clk(clk), .rstn(rstn), .snap_valid(snap_valid), .csr_pack(csr_pack),
        .snap_busy(snap_busy), .out_valid(out_valid), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last), .out_ready(out_ready),
        .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
    );

    csr_trace_serializer #(.HEADER_EN(0), .FRAME_TAG(16'hC5A0)) dut0 (
        .clk(clk), .rstn(rstn), .snap_valid(snap_valid0), .csr_pack(csr_pack),
        .snap_busy(snap_busy0), .out_valid(out_valid0), .out_data(out_data0),
        .out_idx(out_idx0), .out_last(out_last0), .out_ready(out_ready),
        .frame_cnt(frame_cnt0), .drop_cnt(drop_cnt0)
    );

    typedef struct {
        logic [63:0] data;
        logic [4:0]  idx;
        logic        last;
    } beat_t;

    beat_t q1[$];
    beat_t q0[$];
    beat_t e1;
    beat_t e0;
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pattern 0: field k = k+1. Pattern 1: field k = A5A5_0000_0000_0000 | k.
    function automatic logic [63:0] pat(input int sel, input int k);
        if (sel == 0) return 64'(k + 1);
        return 64'hA5A5_0000_0000_0000 | 64'(k);
    endfunction

    task automatic load_pack(input int sel);
        for (int k = 0; k < 27; k++) csr_pack[k] = pat(sel, k);
    endtask

    task automatic push_frame1(input int sel, input logic [31:0] seq);
        q1.push_back('{data: {16'hC5A0, 16'h0000, seq}, idx: 5'd0, last: 1'b0});
        for (int k = 0; k < 27; k++)
            q1.push_back('{data: pat(sel, k), idx: 5'(k + 1), last: (k == 26)});
    endtask

    task automatic push_frame0(input int sel);
        for (int k = 0; k < 27; k++)
            q0.push_back('{data: pat(sel, k), idx: 5'(k), last: (k == 26)});
    endtask

    task automatic do_reset();
        rstn        = 1'b0;
        snap_valid  = 1'b0;
        snap_valid0 = 1'b0;
        out_ready   = 1'b1;
        tick();
        tick();
        q1.delete();
        q0.delete();
        rstn = 1'b1;
    endtask

    task automatic wait_idle1(output int n);
        n = 0;
        while (out_valid && n < 500) begin
            tick();
            n++;
        end
    endtask

    // Monitor for the header-enabled instance, including hold-stability under stall.
    logic        stall_q;
    logic [63:0] hold_data;
    logic [4:0]  hold_idx;
    logic        hold_last;

    always @(negedge clk) begin
        if (!rstn) begin
            stall_q <= 1'b0;
        end else begin
            if (stall_q) begin
                checks++;
                if (!out_valid || out_data !== hold_data || out_idx !== hold_idx || out_last !== hold_last) begin
                    failures++;
                    $display("FAIL hold_stable got=%0h/%0d/%0b exp=%0h/%0d/%0b",
                             out_data, out_idx, out_last, hold_data, hold_idx, hold_last);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q1.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat got=%0h idx=%0d", out_data, out_idx);
                end else begin
                    e1 = q1.pop_front();
                    $display("beat hdr1 idx=%0d data=%h last=%0b", out_idx, out_data, out_last);
                    if (out_data !== e1.data || out_idx !== e1.idx || out_last !== e1.last) begin
                        failures++;
                        $display("FAIL beat got=%0h/%0d/%0b exp=%0h/%0d/%0b",
                                 out_data, out_idx, out_last, e1.data, e1.idx, e1.last);
                    end
                end
            end
            stall_q   <= out_valid && !out_ready;
            hold_data <= out_data;
            hold_idx  <= out_idx;
            hold_last <= out_last;
        end
    end

    // Monitor for the header-disabled instance.
    always @(negedge clk) begin
        if (rstn && out_valid0 && out_ready) begin
            checks++;
            if (q0.size() == 0) begin
                failures++;
                $display("FAIL unexpected_beat0 got=%0h idx=%0d", out_data0, out_idx0);
            end else begin
                e0 = q0.pop_front();
                $display("beat hdr0 idx=%0d data=%h last=%0b", out_idx0, out_data0, out_last0);
                if (out_data0 !== e0.data || out_idx0 !== e0.idx || out_last0 !== e0.last) begin
                    failures++;
                    $display("FAIL beat0 got=%0h/%0d/%0b exp=%0h/%0d/%0b",
                             out_data0, out_idx0, out_last0, e0.data, e0.idx, e0.last);
                end
            end
        end
    end

    initial begin
        int n;
        csr_pack = '0;
        do_reset();

        // Reset state
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_idx", out_idx, 0);
        chk("rst_last", out_last, 0);
        chk("rst_busy", snap_busy, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_valid0", out_valid0, 0);

        // Basic frame
        load_pack(0);
        push_frame1(0, 32'd0);
        snap_valid = 1'b1;
        tick();
        snap_valid = 1'b0;
        chk("t1_latency_valid", out_valid, 1);
        chk("t1_busy", snap_busy, 1);
        chk("t1_first_idx", out_idx, 0);
        wait_idle1(n);
        chk("t1_beats", n, 28);
        chk("t1_frame_cnt", frame_cnt, 1);
        chk("t1_idle_busy", snap_busy, 0);
        chk("t1_q_empty", q1.size(), 0);

        // Backpressure: ready alternates 1/0 starting on the first valid cycle
        do_reset();
        load_pack(0);
        push_frame1(0, 32'd0);
        snap_valid = 1'b1;
        out_ready  = 1'b0;
        tick();
        snap_valid = 1'b0;
        n = 0;
        while (out_valid && n < 500) begin
            out_ready = (n % 2 == 0);
            tick();
            n++;
        end
        out_ready = 1'b1;
        chk("t2_cycles", n, 55);
        chk("t2_frame_cnt", frame_cnt, 1);
        chk("t2_q_empty", q1.size(), 0);

        // Drops at beats 3 and 10 with a changed live bundle
        do_reset();
        load_pack(0);
        push_frame1(0, 32'd0);
        snap_valid = 1'b1;
        tick();
        snap_valid = 1'b0;
        load_pack(1);
        n = 0;
        while (out_valid && n < 500) begin
            snap_valid = (out_idx == 5'd3 || out_idx == 5'd10);
            tick();
            n++;
        end
        snap_valid = 1'b0;
        chk("t3_drop_cnt", drop_cnt, 2);
        chk("t3_frame_cnt", frame_cnt, 1);
        chk("t3_q_empty", q1.size(), 0);
        push_frame1(1, 32'd1);
        snap_valid = 1'b1;
        tick();
        snap_valid = 1'b0;
        wait_idle1(n);
        chk("t3_frame2_beats", n, 28);
        chk("t3_frame_cnt2", frame_cnt, 2);
        chk("t3_q_empty2", q1.size(), 0);

        // Back-to-back frames
        do_reset();
        load_pack(0);
        push_frame1(0, 32'd0);
        snap_valid = 1'b1;
        tick();
        snap_valid = 1'b0;
        n = 0;
        while (!(out_valid && out_last) && n < 100) begin
            tick();
            n++;
        end
        chk("t4_reach_last", n, 27);
        load_pack(1);
        push_frame1(1, 32'd1);
        snap_valid = 1'b1;
        tick();
        snap_valid = 1'b0;
        chk("t4_no_bubble_valid", out_valid, 1);
        chk("t4_no_bubble_idx", out_idx, 0);
        chk("t4_frame_cnt1", frame_cnt, 1);
        wait_idle1(n);
        chk("t4_beats", n, 28);
        chk("t4_frame_cnt2", frame_cnt, 2);
        chk("t4_drop_cnt", drop_cnt, 0);
        chk("t4_q_empty", q1.size(), 0);

        // Reset in the middle of a frame
        do_reset();
        load_pack(0);
        push_frame1(0, 32'd0);
        snap_valid = 1'b1;
        tick();
        snap_valid = 1'b0;
        n = 0;
        while (out_idx != 5'd12 && n < 100) begin
            tick();
            n++;
        end
        chk("t5_reach_12", n, 12);
        rstn = 1'b0;
        tick();
        chk("t5_valid", out_valid, 0);
        chk("t5_busy", snap_busy, 0);
        chk("t5_idx", out_idx, 0);
        chk("t5_frame_cnt", frame_cnt, 0);
        chk("t5_drop_cnt", drop_cnt, 0);
        q1.delete();
        rstn = 1'b1;
        load_pack(1);
        push_frame1(1, 32'd0);
        snap_valid = 1'b1;
        tick();
        snap_valid = 1'b0;
        wait_idle1(n);
        chk("t5_beats", n, 28);
        chk("t5_frame_cnt_after", frame_cnt, 1);
        chk("t5_q_empty", q1.size(), 0);

        // Header disabled instance
        do_reset();
        load_pack(0);
        push_frame0(0);
        snap_valid0 = 1'b1;
        tick();
        snap_valid0 = 1'b0;
        chk("t6_valid", out_valid0, 1);
        chk("t6_word0", out_data0, 64'h1);
        n = 0;
        while (out_valid0 && n < 500) begin
            tick();
            n++;
        end
        chk("t6_beats", n, 27);
        chk("t6_frame_cnt", frame_cnt0, 1);
        chk("t6_q_empty", q0.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "time limit reached");
    end

endmodule
